// File: rtl/cardinal_nic_fifo.sv
// Cardinal NIC with DEPTH-entry input/output FIFOs between processor port and router local port.
// Optional NIC_DROP_CNT_EN adds saturating drop counters in status bits [23:16].
module cardinal_nic_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int IN_DEPTH   = 4,
  parameter int OUT_DEPTH  = 4,
  parameter int VC_BIT     = DATA_WIDTH - 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            addr,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out,
  input  logic                  nicEn,
  input  logic                  nicEnWr,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [DATA_WIDTH-1:0] net_di,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [DATA_WIDTH-1:0] net_do,
  input  logic                  net_polarity
);

  localparam int IN_PW  = (IN_DEPTH  > 1) ? $clog2(IN_DEPTH)  : 1;
  localparam int OUT_PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int IN_CW  = $clog2(IN_DEPTH)  + 1;
  localparam int OUT_CW = $clog2(OUT_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] in_mem  [IN_DEPTH];
  logic [DATA_WIDTH-1:0] out_mem [OUT_DEPTH];
  logic [IN_PW-1:0]      in_wr, in_rd;
  logic [OUT_PW-1:0]     out_wr, out_rd;
  logic [IN_CW-1:0]      in_count;
  logic [OUT_CW-1:0]     out_count;

  logic in_full, in_empty, out_full, out_empty;
  logic in_push, in_pop, out_push, out_pop;
  logic ld_in_status, ld_out_status, st_out_data;
  logic [DATA_WIDTH-1:0] in_head, out_head;
  logic [7:0] in_cnt8, out_cnt8;
  logic [7:0] in_drop_val, out_drop_val;

  assign in_full   = (in_count  == IN_CW'(IN_DEPTH));
  assign in_empty  = (in_count  == '0);
  assign out_full  = (out_count == OUT_CW'(OUT_DEPTH));
  assign out_empty = (out_count == '0);
  assign in_head   = in_mem[in_rd];
  assign out_head  = out_mem[out_rd];
  assign net_ri    = ~in_full;

  assign ld_in_status  = nicEn && !nicEnWr && (addr == 2'b01);
  assign ld_out_status = nicEn && !nicEnWr && (addr == 2'b11);
  assign st_out_data   = nicEn &&  nicEnWr && (addr == 2'b10);

  // Full/empty are judged on the start-of-cycle count, so a pop never frees room for a same-cycle push.
  assign in_push  = net_si && !in_full;
  assign in_pop   = nicEn && !nicEnWr && (addr == 2'b00) && !in_empty;
  assign out_push = st_out_data && !out_full;
  assign out_pop  = !out_empty && net_ro && (out_head[VC_BIT] == net_polarity);

  always_comb begin
    in_cnt8  = (32'(in_count)  > 32'd255) ? 8'hFF : 8'(in_count);
    out_cnt8 = (32'(out_count) > 32'd255) ? 8'hFF : 8'(out_count);
  end

  always_ff @(posedge clk) begin
    if (in_push)  in_mem[in_wr]   <= net_di;
    if (out_push) out_mem[out_wr] <= d_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_wr    <= '0;
      in_rd    <= '0;
      in_count <= '0;
    end else begin
      if (in_push) in_wr <= (in_wr == IN_PW'(IN_DEPTH - 1)) ? '0 : in_wr + IN_PW'(1);
      if (in_pop)  in_rd <= (in_rd == IN_PW'(IN_DEPTH - 1)) ? '0 : in_rd + IN_PW'(1);
      case ({in_push, in_pop})
        2'b10:   in_count <= in_count + IN_CW'(1);
        2'b01:   in_count <= in_count - IN_CW'(1);
        default: in_count <= in_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_wr    <= '0;
      out_rd    <= '0;
      out_count <= '0;
      net_so    <= 1'b0;
      net_do    <= '0;
    end else begin
      if (out_push) out_wr <= (out_wr == OUT_PW'(OUT_DEPTH - 1)) ? '0 : out_wr + OUT_PW'(1);
      if (out_pop) begin
        out_rd <= (out_rd == OUT_PW'(OUT_DEPTH - 1)) ? '0 : out_rd + OUT_PW'(1);
        net_do <= out_head;
      end
      net_so <= out_pop;
      case ({out_push, out_pop})
        2'b10:   out_count <= out_count + OUT_CW'(1);
        2'b01:   out_count <= out_count - OUT_CW'(1);
        default: out_count <= out_count;
      endcase
    end
  end

`ifdef NIC_DROP_CNT_EN
  logic [7:0] in_drop, out_drop;
  logic       in_drop_inc, out_drop_inc;

  assign in_drop_inc  = net_si && in_full;
  assign out_drop_inc = st_out_data && out_full;

  // A status read clears its counter, but a drop in that same cycle is still recorded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_drop  <= '0;
      out_drop <= '0;
    end else begin
      if (ld_in_status)                      in_drop <= in_drop_inc ? 8'd1 : 8'd0;
      else if (in_drop_inc && in_drop != '1) in_drop <= in_drop + 8'd1;
      if (ld_out_status)                       out_drop <= out_drop_inc ? 8'd1 : 8'd0;
      else if (out_drop_inc && out_drop != '1) out_drop <= out_drop + 8'd1;
    end
  end

  assign in_drop_val  = in_drop;
  assign out_drop_val = out_drop;
`else
  assign in_drop_val  = '0;
  assign out_drop_val = '0;
`endif

  always_comb begin
    d_out = '0;
    if (nicEn && !nicEnWr) begin
      case (addr)
        2'b00: d_out = in_head;
        2'b01: begin
          d_out[0]     = ~in_empty;
          d_out[15:8]  = in_cnt8;
          d_out[23:16] = in_drop_val;
        end
        2'b11: begin
          d_out[0]     = out_full;
          d_out[15:8]  = out_cnt8;
          d_out[23:16] = out_drop_val;
        end
        default: d_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_cardinal_nic_fifo.sv
// Directed self-checking bench for cardinal_nic_fifo (default 64-bit, depth 4 configuration).
module tb_cardinal_nic_fifo;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    addr;
  logic [DW-1:0] d_in, d_out, net_di, net_do;
  logic          nicEn, nicEnWr, net_si, net_ri, net_so, net_ro, net_polarity;

  int checks = 0;
  int errors = 0;

  cardinal_nic_fifo #(
    .DATA_WIDTH(DW),
    .IN_DEPTH  (4),
    .OUT_DEPTH (4),
    .VC_BIT    (DW - 1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .addr        (addr),
    .d_in        (d_in),
    .d_out       (d_out),
    .nicEn       (nicEn),
    .nicEnWr     (nicEnWr),
    .net_si      (net_si),
    .net_ri      (net_ri),
    .net_di      (net_di),
    .net_so      (net_so),
    .net_ro      (net_ro),
    .net_do      (net_do),
    .net_polarity(net_polarity)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_proc();
    nicEn = 1'b0; nicEnWr = 1'b0; addr = 2'b00; d_in = '0;
  endtask

  task automatic set_load(input logic [1:0] a);
    nicEn = 1'b1; nicEnWr = 1'b0; addr = a;
    #1;
  endtask

  task automatic set_store(input logic [DW-1:0] v);
    nicEn = 1'b1; nicEnWr = 1'b1; addr = 2'b10; d_in = v;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_proc();
    net_si = 1'b0; net_di = '0; net_ro = 1'b0; net_polarity = 1'b0;
    #12;
    reset = 1'b1;
    #2;
    checks++; if (net_ri !== 1'b1) begin errors++; $display("FAIL reset_ri: got %b expected 1", net_ri); end
    checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL reset_so: got %b expected 0", net_so); end
    set_load(2'b01);
    checks++; if (d_out !== 64'h0) begin errors++; $display("FAIL reset_st01: got %h expected 0", d_out); end
    set_load(2'b11);
    checks++; if (d_out !== 64'h0) begin errors++; $display("FAIL reset_st11: got %h expected 0", d_out); end
    idle_proc();
    cyc();
  endtask

  task automatic test_single_send();
    net_ro = 1'b1; net_polarity = 1'b1;
    set_store(64'hDEADBEEFDEADBEEF);
    cyc();
    idle_proc();
    checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL send_latency: got %b expected 0", net_so); end
    cyc();
    checks++; if (net_so !== 1'b1 || net_do !== 64'hDEADBEEFDEADBEEF) begin
      errors++; $display("FAIL send_pkt: got so=%b do=%h expected so=1 do=deadbeefdeadbeef", net_so, net_do); end
    cyc();
    checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL send_one_cycle: got %b expected 0", net_so); end
    set_load(2'b11);
    checks++; if (d_out !== 64'h0) begin errors++; $display("FAIL send_st11: got %h expected 0", d_out); end
    idle_proc();
  endtask

  task automatic test_polarity_block();
    net_ro = 1'b0;
    set_store(64'hCAFEBABECAFEBABE); cyc();
    set_store(64'h0123456789ABCDEF); cyc();
    idle_proc();
    set_load(2'b11);
    checks++; if (d_out !== 64'h200) begin errors++; $display("FAIL pol_st11: got %h expected 200", d_out); end
    idle_proc();
    net_ro = 1'b1; net_polarity = 1'b1;
    cyc();
    checks++; if (net_so !== 1'b1 || net_do !== 64'hCAFEBABECAFEBABE) begin
      errors++; $display("FAIL pol_cafe: got so=%b do=%h expected so=1 do=cafebabecafebabe", net_so, net_do); end
    cyc();
    checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL pol_block1: got %b expected 0", net_so); end
    cyc();
    checks++; if (net_so !== 1'b0 || net_do !== 64'hCAFEBABECAFEBABE) begin
      errors++; $display("FAIL pol_block2: got so=%b do=%h expected so=0 do=cafebabecafebabe", net_so, net_do); end
    net_polarity = 1'b0;
    cyc();
    checks++; if (net_so !== 1'b1 || net_do !== 64'h0123456789ABCDEF) begin
      errors++; $display("FAIL pol_0123: got so=%b do=%h expected so=1 do=0123456789abcdef", net_so, net_do); end
    net_ro = 1'b0;
    cyc();
  endtask

  task automatic test_input_fifo();
    logic [DW-1:0] pk [3];
    pk[0] = 64'hA5A5A5A5A5A5A5A5;
    pk[1] = 64'h5A5A5A5A5A5A5A5A;
    pk[2] = 64'h1111111111111111;
    for (int i = 0; i < 3; i++) begin
      net_si = 1'b1; net_di = pk[i];
      cyc();
    end
    net_si = 1'b0;
    set_load(2'b01);
    checks++; if (d_out !== 64'h301) begin errors++; $display("FAIL in_st01: got %h expected 301", d_out); end
    for (int i = 0; i < 3; i++) begin
      set_load(2'b00);
      checks++; if (d_out !== pk[i]) begin errors++; $display("FAIL in_pop%0d: got %h expected %h", i, d_out, pk[i]); end
      cyc();
    end
    set_load(2'b01);
    checks++; if (d_out !== 64'h0) begin errors++; $display("FAIL in_st01_empty: got %h expected 0", d_out); end
    idle_proc();
    cyc();
  endtask

  task automatic test_output_full();
    logic [DW-1:0] exp_st;
`ifdef NIC_DROP_CNT_EN
    exp_st = 64'h10401;
`else
    exp_st = 64'h401;
`endif
    net_ro = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      set_store(64'(i)); cyc();
    end
    set_store(64'hFFFFFFFFFFFFFFFF); cyc();
    idle_proc();
    set_load(2'b11);
    checks++; if (d_out !== exp_st) begin errors++; $display("FAIL out_full_st11: got %h expected %h", d_out, exp_st); end
    idle_proc();
    net_ro = 1'b1; net_polarity = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      checks++; if (net_so !== 1'b1 || net_do !== 64'(i)) begin
        errors++; $display("FAIL out_drain%0d: got so=%b do=%h expected so=1 do=%h", i, net_so, net_do, 64'(i)); end
    end
    cyc();
    checks++; if (net_so !== 1'b0 || net_do !== 64'h4) begin
      errors++; $display("FAIL out_no_extra: got so=%b do=%h expected so=0 do=4", net_so, net_do); end
    net_ro = 1'b0;
  endtask

  task automatic test_full_pushpop_and_reset();
    logic [DW-1:0] exp_st;
`ifdef NIC_DROP_CNT_EN
    exp_st = 64'h10301;
`else
    exp_st = 64'h301;
`endif
    for (int i = 0; i < 4; i++) begin
      net_si = 1'b1; net_di = 64'h10 + 64'(i);
      cyc();
    end
    checks++; if (net_ri !== 1'b0) begin errors++; $display("FAIL full_ri: got %b expected 0", net_ri); end
    net_di = 64'h99;
    set_load(2'b00);
    checks++; if (d_out !== 64'h10) begin errors++; $display("FAIL full_head: got %h expected 10", d_out); end
    cyc();
    net_si = 1'b0;
    set_load(2'b01);
    checks++; if (d_out !== exp_st) begin errors++; $display("FAIL full_st01: got %h expected %h", d_out, exp_st); end
    set_load(2'b00);
    checks++; if (d_out !== 64'h11) begin errors++; $display("FAIL full_next_head: got %h expected 11", d_out); end
    idle_proc();
    // queue two packets, let the first go out, then hit reset while net_so is high
    net_ro = 1'b0; net_polarity = 1'b1;
    set_store(64'h8000000000000077); cyc();
    set_store(64'h8000000000000088); cyc();
    idle_proc();
    net_ro = 1'b1;
    cyc();
    checks++; if (net_so !== 1'b1 || net_do !== 64'h8000000000000077) begin
      errors++; $display("FAIL rst_pre_so: got so=%b do=%h expected so=1 do=8000000000000077", net_so, net_do); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (net_so !== 1'b0 || net_do !== 64'h0) begin
      errors++; $display("FAIL rst_async: got so=%b do=%h expected so=0 do=0", net_so, net_do); end
    set_load(2'b01);
    checks++; if (d_out !== 64'h0) begin errors++; $display("FAIL rst_st01: got %h expected 0", d_out); end
    set_load(2'b11);
    checks++; if (d_out !== 64'h0) begin errors++; $display("FAIL rst_st11: got %h expected 0", d_out); end
    idle_proc();
    net_ro = 1'b0;
    #3;
    reset = 1'b1;
    cyc();
    cyc();
    checks++; if (net_so !== 1'b0 || net_ri !== 1'b1) begin
      errors++; $display("FAIL rst_after: got so=%b ri=%b expected so=0 ri=1", net_so, net_ri); end
  endtask

  initial begin
    test_reset();
    test_single_send();
    test_polarity_block();
    test_input_fifo();
    test_output_full();
    test_full_pushpop_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cardinal_nic_fifo.md
Name: cardinal_nic_fifo

Overview:
Parametrised successor to the single-entry Cardinal NIC, sitting between a processor's memory-mapped NIC port and its mesh router's local port. It replaces each one-entry input/output buffer with a DEPTH-entry FIFO and exposes occupancy in the status words. Its register map stays compatible with the single-entry NIC.

Parameters:
DATA_WIDTH, 64, packet/data width in bits; DATA_WIDTH >= 24
IN_DEPTH, 4, input FIFO entries; power of two, 1..128
OUT_DEPTH, 4, output FIFO entries; power of two, 1..128
VC_BIT, DATA_WIDTH-1, packet bit carrying the virtual-channel/polarity tag

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
addr  input  2  register select: 00 in-data, 01 in-status, 10 out-data, 11 out-status
d_in  input  DATA_WIDTH  processor store data
d_out  output  DATA_WIDTH  processor load data, combinational
nicEn  input  1  NIC access enable
nicEnWr  input  1  1 = store, 0 = load (qualified by nicEn)
net_si  input  1  router delivers packet
net_ri  output  1  NIC can accept a packet
net_di  input  DATA_WIDTH  router packet in
net_so  output  1  NIC injects packet (registered)
net_ro  input  1  router can accept
net_do  output  DATA_WIDTH  injected packet (registered)
net_polarity  input  1  router's current cycle polarity

Behaviour:
- Reset (reset=0, async): both FIFOs empty, pointers/counts 0, net_so=0, net_do=0. net_ri=1 immediately after reset deassertion.
- net_ri = input FIFO not full (combinational from count).
- Input push: on clk edge, if net_si && net_ri, net_di is written at the tail. net_si while full: packet dropped, no state change.
- Loads (nicEn=1, nicEnWr=0), d_out combinational:
  - addr 00: d_out = input head.
  - addr 01: d_out = status word: bit0 = input non-empty, bits[15:8] = input count, other bits 0.
  - addr 11: d_out = status word: bit0 = output full, bits[15:8] = output count, other bits 0.
  - addr 10: d_out = 0.
  - When nicEn=0, d_out = 0.
- Load pop: a load at addr 00 with the input FIFO non-empty pops the head at the clk edge. A load from an empty FIFO returns the stale head slot and leaves the FIFO unchanged.
- Store (nicEn=1, nicEnWr=1, addr 10): on clk edge, if the output FIFO is not full, d_in is written at the tail. If full, the store is ignored. Stores to other addresses are ignored.
- Injection, evaluated each edge:
  - If output non-empty && net_ro && head[VC_BIT]==net_polarity: net_so<=1, net_do<=head, pop head.
  - Otherwise net_so<=0 and net_do holds its last value.
  - One-cycle latency from eligibility to net_so; at most one packet per cycle.
  - A non-matching head blocks later entries (strict FIFO order, no reordering).
- Simultaneous events:
  - Push and pop on the same FIFO in one cycle: both occur, count unchanged.
  - Full FIFO: a push is rejected even if a pop occurs in the same cycle; full is judged at the start of the cycle.
  - Input push and processor pop are independent; the same holds for store and injection.
- Pointers wrap modulo depth. Count width is clog2(depth)+1; the count saturates the status field at 255.
- Reset mid-operation: all buffered packets are discarded and net_so falls asynchronously.

Optional Feature:
Macro NIC_DROP_CNT_EN.
- Defined: two 8-bit saturating counters, reset to 0.
  - in_drop counts net_si while the input FIFO is full; reported in status 01 bits[23:16].
  - out_drop counts stores ignored while the output FIFO is full; reported in status 11 bits[23:16].
  - A load of a status word clears its counter on that edge; an increment in the same cycle wins, leaving the counter at 1.
- Undefined: no counters; bits[23:16] read 0.

Test Plan:
1. Hold reset=0 10 ns, release -> net_ri=1, net_so=0, status 01 = 0, status 11 = 0.
2. Store 0xDEADBEEFDEADBEEF, net_ro=1, net_polarity=1 -> net_so=1 with net_do=0xDEADBEEFDEADBEEF one cycle later, for one cycle; status 11 returns to 0.
3. net_ro=0, store 0xCAFEBABECAFEBABE then 0x0123456789ABCDEF -> status 11 = 0x200. Set net_ro=1, polarity=1 -> CAFE packet sent; then 0123 head blocks (bit63=0); net_so=0 until polarity=0, then it is sent.
4. Router pushes 0xA5.., 0x5A.., 0x11.. -> status 01 = 0x301. Three addr-00 loads return them in order; status 01 = 0.
5. net_ro=0, fill output with OUT_DEPTH=4 stores, then a 5th store 0xFFFF..FF -> status 11 = 0x401 (with NIC_DROP_CNT_EN: 0x10401). A subsequent send drains the original 4 in order, without the 0xFF.. packet.
6. Input FIFO full, net_si held with processor pop in the same cycle -> net_ri=0, push rejected, count drops 4->3. Assert reset mid-transfer -> net_so falls immediately and counts are 0.
